parking_gate_arbiter: RTL

- Sequencer that shares the single entry/cost memory port between the entry gate and the exit gate of the 3-slot parking system.
- Latches enter/exit requests, arbitrates them round-robin, and drives the memory write strobes and slot select.
- Computes the exit cost from the stored entry time and times the gate-open pulse from the 1 Hz tick.
- Sits between the push-button/sensor inputs and the memory, flags and seven-segment display logic.

---
 rtl/parking_pkg.sv | 22 ++
 rtl/parking_cost_calc.sv | 28 ++
 rtl/parking_gate_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking system gate/memory sequencer.
package parking_pkg;

    localparam int unsigned TIME_W  = 10;
    localparam int unsigned COST_W  = 10;
    localparam int unsigned N_SLOTS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY_WR,
        ST_EXIT_RD,
        ST_EXIT_CALC,
        ST_EXIT_WR,
        ST_GATE
    } state_t;

    // Exactly one bit of the slot select is set.
    function automatic logic is_one_hot(input logic [N_SLOTS-1:0] sel);
        return (sel != '0) && ((sel & (sel - N_SLOTS'(1))) == '0);
    endfunction

endpackage

// File: rtl/parking_cost_calc.sv
// Combinational parking cost: modulo-2^TIME_W elapsed time, optional free period, saturated at COST_MAX.
module parking_cost_calc
    import parking_pkg::*;
#(
    parameter int unsigned RATE      = 2,
    parameter int unsigned COST_MAX  = 999,
    parameter int unsigned FREE_SECS = 0
) (
    input  logic [TIME_W-1:0] entry_time,
    input  logic [TIME_W-1:0] now,
    output logic [COST_W-1:0] cost
);

    localparam int unsigned PROD_W = TIME_W + 16;

    logic [TIME_W-1:0] elapsed;
    logic [TIME_W-1:0] billable;
    logic [PROD_W-1:0] prod;

    // Wrapping subtraction handles timer rollover between entry and exit.
    always_comb begin
        elapsed  = now - entry_time;
        billable = (elapsed > TIME_W'(FREE_SECS)) ? elapsed - TIME_W'(FREE_SECS) : '0;
        prod     = PROD_W'(billable) * PROD_W'(RATE);
        cost     = (prod > PROD_W'(COST_MAX)) ? COST_W'(COST_MAX) : prod[COST_W-1:0];
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Entry/exit gate sequencer sharing one memory port; round-robin arbitration and gate timing.
// Optional free-parking period enabled by defining PARK_FREE_PERIOD_EN.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned RATE       = 2,
    parameter int unsigned GATE_TICKS = 3,
    parameter int unsigned COST_MAX   = 999,
    parameter int unsigned FREE_SECS  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic [TIME_W-1:0]  timer_count,
    input  logic               car_enter,
    input  logic               car_exit,
    input  logic [N_SLOTS-1:0] enter_sel,
    input  logic [N_SLOTS-1:0] exit_sel,
    input  logic [N_SLOTS-1:0] occupied,
    input  logic [TIME_W-1:0]  entry_time_out,
    output logic [N_SLOTS-1:0] mem_sel,
    output logic               write_entry,
    output logic               write_cost,
    output logic [TIME_W-1:0]  entry_time_in,
    output logic [COST_W-1:0]  cost_in,
    output logic [COST_W-1:0]  current_cost,
    output logic [N_SLOTS-1:0] slot_set,
    output logic [N_SLOTS-1:0] slot_clr,
    output logic               gate_open,
    output logic               reject,
    output logic               busy
);

`ifdef PARK_FREE_PERIOD_EN
    localparam int unsigned FREE_EFF = FREE_SECS;
`else
    // Free period disabled: a zero threshold bills every elapsed second.
    localparam int unsigned FREE_EFF = FREE_SECS * 0;
`endif
    localparam int unsigned TICK_W = $clog2(GATE_TICKS + 1);

    state_t             state, state_next;
    logic               enter_q, exit_q;
    logic               enter_pend, exit_pend;
    logic [N_SLOTS-1:0] enter_slot, exit_slot, slot;
    logic               prio_exit;
    logic [TICK_W-1:0]  tick_cnt;
    logic               grant_enter, grant_exit, grant_ok;
    logic [COST_W-1:0]  cost_calc;

    parking_cost_calc #(
        .RATE      (RATE),
        .COST_MAX  (COST_MAX),
        .FREE_SECS (FREE_EFF)
    ) u_cost_calc (
        .entry_time (entry_time_out),
        .now        (timer_count),
        .cost       (cost_calc)
    );

    // State register plus request latches, priority, gate tick counter and held cost.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            enter_q      <= 1'b0;
            exit_q       <= 1'b0;
            enter_pend   <= 1'b0;
            exit_pend    <= 1'b0;
            enter_slot   <= '0;
            exit_slot    <= '0;
            slot         <= '0;
            prio_exit    <= 1'b0;
            tick_cnt     <= '0;
            reject       <= 1'b0;
            current_cost <= '0;
        end else begin
            state   <= state_next;
            enter_q <= car_enter;
            exit_q  <= car_exit;
            reject  <= (grant_enter || grant_exit) && !grant_ok;

            // A grant clears its flag and swallows an edge arriving in the same clk.
            if (grant_enter) begin
                enter_pend <= 1'b0;
            end else if (car_enter && !enter_q && !enter_pend) begin
                enter_pend <= 1'b1;
                enter_slot <= enter_sel;
            end
            if (grant_exit) begin
                exit_pend <= 1'b0;
            end else if (car_exit && !exit_q && !exit_pend) begin
                exit_pend <= 1'b1;
                exit_slot <= exit_sel;
            end

            if ((grant_enter || grant_exit) && enter_pend && exit_pend) begin
                prio_exit <= ~prio_exit;
            end
            if (grant_ok) begin
                slot <= grant_enter ? enter_slot : exit_slot;
            end

            if (state == ST_GATE) begin
                if (tick_1hz) begin
                    tick_cnt <= (tick_cnt == TICK_W'(GATE_TICKS - 1)) ? '0 : tick_cnt + TICK_W'(1);
                end
            end else begin
                tick_cnt <= '0;
            end

            if (state == ST_EXIT_CALC) begin
                current_cost <= cost_calc;
            end
        end
    end

    // Next state, arbitration and grant-time validation.
    always_comb begin
        state_next  = state;
        grant_enter = 1'b0;
        grant_exit  = 1'b0;
        grant_ok    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enter_pend && (!exit_pend || !prio_exit)) begin
                    grant_enter = 1'b1;
                    grant_ok    = is_one_hot(enter_slot) && ((enter_slot & occupied) == '0);
                    if (grant_ok) state_next = ST_ENTRY_WR;
                end else if (exit_pend) begin
                    grant_exit = 1'b1;
                    grant_ok   = is_one_hot(exit_slot) && ((exit_slot & occupied) != '0);
                    if (grant_ok) state_next = ST_EXIT_RD;
                end
            end
            ST_ENTRY_WR:  state_next = ST_GATE;
            ST_EXIT_RD:   state_next = ST_EXIT_CALC;
            ST_EXIT_CALC: state_next = ST_EXIT_WR;
            ST_EXIT_WR:   state_next = ST_GATE;
            ST_GATE: begin
                if (tick_1hz && (tick_cnt == TICK_W'(GATE_TICKS - 1))) state_next = ST_IDLE;
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        mem_sel       = '0;
        write_entry   = 1'b0;
        write_cost    = 1'b0;
        entry_time_in = '0;
        cost_in       = '0;
        slot_set      = '0;
        slot_clr      = '0;
        gate_open     = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_ENTRY_WR: begin
                mem_sel       = slot;
                entry_time_in = timer_count;
                write_entry   = 1'b1;
                slot_set      = slot;
            end
            ST_EXIT_RD, ST_EXIT_CALC: begin
                mem_sel = slot;
            end
            ST_EXIT_WR: begin
                mem_sel    = slot;
                cost_in    = current_cost;
                write_cost = 1'b1;
                slot_clr   = slot;
            end
            ST_GATE:     gate_open = 1'b1;
            default:     ;
        endcase
    end

endmodule
